// File: rtl/conv_patch_window_gen.sv
// 3x3 valid-convolution window generator over a raster pixel stream, two line buffers deep.
// Optional PATCH_COORD_EN adds patch_row/patch_col (window top-left position) outputs.
module conv_patch_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [9*DATA_W-1:0]   patch_flat,
    output logic                  patch_valid,
    input  logic                  patch_ready,
    output logic                  patch_last
`ifdef PATCH_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0] patch_row,
    output logic [$clog2(IMG_W)-1:0] patch_col
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] win [3][3];
    logic [DATA_W-1:0] newcol [3];
    logic [9*DATA_W-1:0] next_patch;
    logic accept;
    logic emit;
    logic col_end;
    logic row_end;

    assign pix_ready = !patch_valid || patch_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = (col == CW'(IMG_W - 1));
    assign row_end   = (row == RW'(IMG_H - 1));
    // Row/column gates exclude stale line-buffer data and windows straddling a row wrap.
    assign emit      = accept && (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        newcol[0] = lb1[col];
        newcol[1] = lb0[col];
        newcol[2] = pix_data;
    end

    always_comb begin
        next_patch = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            next_patch[(r*3+0)*DATA_W +: DATA_W] = win[r][1];
            next_patch[(r*3+1)*DATA_W +: DATA_W] = win[r][2];
            next_patch[(r*3+2)*DATA_W +: DATA_W] = newcol[r];
        end
    end

    // Line buffers and window are never reset; the emit gates hide their contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= newcol[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            patch_flat  <= '0;
            patch_valid <= 1'b0;
            patch_last  <= 1'b0;
`ifdef PATCH_COORD_EN
            patch_row   <= '0;
            patch_col   <= '0;
`endif
        end else begin
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (emit) begin
                patch_flat  <= next_patch;
                patch_valid <= 1'b1;
                patch_last  <= row_end && col_end;
`ifdef PATCH_COORD_EN
                patch_row   <= row - RW'(2);
                patch_col   <= col - CW'(2);
`endif
            end else if (patch_valid && patch_ready) begin
                patch_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_patch_window_gen.sv
// Directed bench for conv_patch_window_gen: 4x4 frames (plain, stalled, back-to-back, mid-frame reset)
// and a randomly throttled 28x28 frame checked against a stored-frame reference.
module tb_conv_patch_window_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0]  pix_data4, pix_data28;
    logic         pix_valid4, pix_valid28;
    logic         pix_ready4, pix_ready28;
    logic [287:0] patch_flat4, patch_flat28;
    logic         patch_valid4, patch_valid28;
    logic         patch_ready4, patch_ready28;
    logic         patch_last4, patch_last28;
`ifdef PATCH_COORD_EN
    logic [1:0] patch_row4, patch_col4;
    logic [4:0] patch_row28, patch_col28;
`endif

    conv_patch_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) dut4 (
        .clk(clk), .reset(reset),
        .pix_data(pix_data4), .pix_valid(pix_valid4), .pix_ready(pix_ready4),
        .patch_flat(patch_flat4), .patch_valid(patch_valid4),
        .patch_ready(patch_ready4), .patch_last(patch_last4)
`ifdef PATCH_COORD_EN
        , .patch_row(patch_row4), .patch_col(patch_col4)
`endif
    );

    conv_patch_window_gen #(.IMG_W(28), .IMG_H(28), .DATA_W(32)) dut28 (
        .clk(clk), .reset(reset),
        .pix_data(pix_data28), .pix_valid(pix_valid28), .pix_ready(pix_ready28),
        .patch_flat(patch_flat28), .patch_valid(patch_valid28),
        .patch_ready(patch_ready28), .patch_last(patch_last28)
`ifdef PATCH_COORD_EN
        , .patch_row(patch_row28), .patch_col(patch_col28)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit to4  = 1'b0;
    bit to28 = 1'b0;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Captured transfers, sampled on the falling edge ahead of the transferring rising edge
    logic [287:0] q4_flat[$];
    logic         q4_last[$];
    int           q4_cnt[$];
    int           q4_row[$];
    int           q4_col[$];
    int           acc4 = 0;
    logic [287:0] q28_flat[$];
    logic         q28_last[$];
    logic [31:0]  px28 [784];

    always @(negedge clk) begin
        if (reset) begin
            acc4 = 0;
        end else begin
            if (patch_valid4 && patch_ready4) begin
                q4_flat.push_back(patch_flat4);
                q4_last.push_back(patch_last4);
                q4_cnt.push_back(acc4);
`ifdef PATCH_COORD_EN
                q4_row.push_back(int'(patch_row4));
                q4_col.push_back(int'(patch_col4));
`endif
            end
            if (pix_valid4 && pix_ready4) acc4++;
            if (patch_valid28 && patch_ready28) begin
                q28_flat.push_back(patch_flat28);
                q28_last.push_back(patch_last28);
            end
        end
    end

    function automatic logic [287:0] exp4(input int base, input int r0, input int c0);
        logic [287:0] p;
        p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(r*3+c)*32 +: 32] = 32'(base + (r0 + r) * 4 + c0 + c);
        return p;
    endfunction

    function automatic logic [287:0] exp28(input int r0, input int c0);
        logic [287:0] p;
        p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(r*3+c)*32 +: 32] = px28[(r0 + r) * 28 + c0 + c];
        return p;
    endfunction

    task automatic send4(input logic [31:0] v);
        int n;
        n = 0;
        pix_valid4 = 1'b1;
        pix_data4  = v;
        forever begin
            @(negedge clk);
            if (pix_ready4) break;
            if (++n > 200) begin to4 = 1'b1; break; end
        end
        @(posedge clk); #1;
        pix_valid4 = 1'b0;
    endtask

    task automatic send28(input logic [31:0] v);
        int n;
        n = 0;
        pix_valid28 = 1'b1;
        pix_data28  = v;
        forever begin
            @(negedge clk);
            if (pix_ready28) break;
            if (++n > 200) begin to28 = 1'b1; break; end
        end
        @(posedge clk); #1;
        pix_valid28 = 1'b0;
    endtask

    task automatic clear4();
        q4_flat.delete(); q4_last.delete(); q4_cnt.delete();
        q4_row.delete();  q4_col.delete();
    endtask

    task automatic check_frames4(input string tag, input int nframes, input int base1, input bit chk_cnt);
        int exp_cnt [4];
        int f, j;
        exp_cnt = '{11, 12, 15, 16};
        check({tag, "_count"}, 288'(q4_flat.size()), 288'(4 * nframes));
        for (int i = 0; i < q4_flat.size() && i < 4 * nframes; i++) begin
            f = i / 4;
            j = i % 4;
            check($sformatf("%s_flat%0d", tag, i), q4_flat[i], exp4(f == 0 ? 0 : base1, j / 2, j % 2));
            check($sformatf("%s_last%0d", tag, i), 288'(q4_last[i]), 288'(j == 3));
            if (chk_cnt)
                check($sformatf("%s_lat%0d", tag, i), 288'(q4_cnt[i]), 288'(exp_cnt[j]));
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        pix_data4 = '0;  pix_valid4 = 1'b0;  patch_ready4 = 1'b1;
        pix_data28 = '0; pix_valid28 = 1'b0; patch_ready28 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 288'(patch_valid4), 288'(0));
        check("rst_last",  288'(patch_last4),  288'(0));
        check("rst_flat",  patch_flat4, '0);
        check("rst_pix_ready", 288'(pix_ready4), 288'(1));
        @(posedge clk); #1;

        // Single 4x4 frame, no backpressure
        clear4();
        for (int i = 0; i < 16; i++) send4(32'(i));
        repeat (3) @(negedge clk);
        check_frames4("basic", 1, 0, 1'b1);
`ifdef PATCH_COORD_EN
        for (int i = 0; i < q4_row.size() && i < 4; i++) begin
            check($sformatf("coord_row%0d", i), 288'(q4_row[i]), 288'(i / 2));
            check($sformatf("coord_col%0d", i), 288'(q4_col[i]), 288'(i % 2));
        end
`endif
        @(posedge clk); #1;

        // Stall the first patch for 5 cycles
        clear4();
        patch_ready4 = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send4(32'(i));
            end
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!patch_valid4 && n < 100);
                if (n >= 100) to4 = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check($sformatf("stall_pix_ready%0d", k), 288'(pix_ready4), 288'(0));
                    check($sformatf("stall_hold%0d", k), patch_flat4, exp4(0, 0, 0));
                end
                @(posedge clk); #1;
                patch_ready4 = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check_frames4("stall", 1, 0, 1'b0);
        @(posedge clk); #1;

        // Back-to-back frames with no gap
        clear4();
        for (int i = 0; i < 16; i++) send4(32'(i));
        for (int i = 0; i < 16; i++) send4(32'(100 + i));
        repeat (3) @(negedge clk);
        check_frames4("b2b", 2, 100, 1'b0);
        @(posedge clk); #1;

        // Reset mid-frame after pixel 9
        clear4();
        for (int i = 0; i < 10; i++) send4(32'(i));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mrst_valid", 288'(patch_valid4), 288'(0));
        check("mrst_pix_ready", 288'(pix_ready4), 288'(1));
        check("mrst_no_patch", 288'(q4_flat.size()), 288'(0));
        @(posedge clk); #1;
        clear4();
        for (int i = 0; i < 16; i++) send4(32'(i));
        repeat (3) @(negedge clk);
        check_frames4("mrst", 1, 0, 1'b1);
        @(posedge clk); #1;

        // 28x28 frame with random input gaps and random downstream ready
        for (int i = 0; i < 784; i++) px28[i] = $urandom;
        q28_flat.delete(); q28_last.delete();
        fork
            begin
                for (int i = 0; i < 784; i++) begin
                    if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                    send28(px28[i]);
                end
            end
            begin
                n = 0;
                while (q28_flat.size() < 676 && n < 20000) begin
                    @(posedge clk); #1;
                    patch_ready28 = 1'($urandom_range(0, 1));
                    n++;
                end
                if (n >= 20000) to28 = 1'b1;
                patch_ready28 = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("rnd_count", 288'(q28_flat.size()), 288'(676));
        for (int i = 0; i < q28_flat.size() && i < 676; i++) begin
            check($sformatf("rnd_flat%0d", i), q28_flat[i], exp28(i / 26, i % 26));
            check($sformatf("rnd_last%0d", i), 288'(q28_last[i]), 288'(i == 675));
        end

        check("px4_timeout", 288'(to4), 288'(0));
        check("px28_timeout", 288'(to28), 288'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
